// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory access controller:
// FSM state encoding, read-only window defaults, MMIO map and the write-protect check.
package mem_access_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam logic [7:0] RO_LO_DEF = 8'h4E;
   localparam logic [7:0] RO_HI_DEF = 8'h51;

   localparam logic [7:0] SSEG_LO   = 8'h28;
   localparam logic [7:0] SSEG_HI   = 8'h2B;
   localparam logic [7:0] LED_LO    = 8'h44;
   localparam logic [7:0] LED_HI    = 8'h45;
   localparam logic [7:0] SW_LO     = 8'h4E;
   localparam logic [7:0] SW_HI     = 8'h4F;
   localparam logic [7:0] BTNS_ADDR = 8'h51;

   // A 16-bit beat touches addr and addr+1 (mod 256); either byte in the window blocks it.
   function automatic logic is_ro(input logic [7:0] addr,
                                  input logic [7:0] lo,
                                  input logic [7:0] hi);
      logic [7:0] addr_p1;
      addr_p1 = addr + 8'd1;
      return ((addr >= lo) && (addr <= hi)) || ((addr_p1 >= lo) && (addr_p1 <= hi));
   endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Bus-side initiator for the 16-bit data memory: turns CPU load/store requests
// into one or two registered read/write beats and returns a held response.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where resp_valid && resp_ready. The
// request fields are only sampled at their transfer edge, and resp_rdata /
// resp_err stay stable for as long as resp_valid is high.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter logic [7:0] RO_LO = RO_LO_DEF,
   parameter logic [7:0] RO_HI = RO_HI_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_wide,
   input  logic [7:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [7:0]  mem_address,
   output logic        mem_read_en,
   output logic        mem_write_en,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_BEAT0 = BEAT0;
   localparam logic [1:0] S_BEAT1 = BEAT1;
   localparam logic [1:0] S_RESP  = RESP;

   logic [1:0]  state;
   logic        write_q;
   logic        wide_q;
   logic [7:0]  addr_q;
   logic [15:0] wdata_lo_q;
   logic [15:0] rdata_hi_q;
   logic        err_q;

   logic [7:0]  addr_p2;
   logic        ro_beat0;
   logic        ro_beat1;

   always_comb begin
      addr_p2  = addr_q + 8'd2;
      ro_beat0 = is_ro(req_addr, RO_LO, RO_HI);
      ro_beat1 = is_ro(addr_p2, RO_LO, RO_HI);
   end

   assign dbg_state = state;

   // Every output is a flop; beat enables are set on the edge that enters a BEAT state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= S_IDLE;
         write_q      <= 1'b0;
         wide_q       <= 1'b0;
         addr_q       <= 8'h00;
         wdata_lo_q   <= 16'h0000;
         rdata_hi_q   <= 16'h0000;
         err_q        <= 1'b0;
         req_ready    <= 1'b0;
         resp_valid   <= 1'b0;
         resp_rdata   <= 32'h0000_0000;
         resp_err     <= 1'b0;
         mem_address  <= 8'h00;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         mem_wdata    <= 16'h0000;
      end else begin
         case (state)
            S_IDLE: begin
               mem_read_en  <= 1'b0;
               mem_write_en <= 1'b0;
               resp_valid   <= 1'b0;
               if (req_valid && req_ready) begin
                  state        <= S_BEAT0;
                  req_ready    <= 1'b0;
                  write_q      <= req_write;
                  wide_q       <= req_wide;
                  addr_q       <= req_addr;
                  wdata_lo_q   <= req_wdata[15:0];
                  rdata_hi_q   <= 16'h0000;
                  mem_address  <= req_addr;
                  mem_wdata    <= req_wide ? req_wdata[31:16] : req_wdata[15:0];
                  mem_read_en  <= !req_write;
                  mem_write_en <= req_write && !ro_beat0;
                  err_q        <= req_write && ro_beat0;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            S_BEAT0: begin
               if (wide_q) begin
                  state        <= S_BEAT1;
                  rdata_hi_q   <= mem_rdata;
                  mem_address  <= addr_p2;
                  mem_wdata    <= wdata_lo_q;
                  mem_read_en  <= !write_q;
                  mem_write_en <= write_q && !ro_beat1;
                  err_q        <= err_q || (write_q && ro_beat1);
               end else begin
                  state        <= S_RESP;
                  mem_read_en  <= 1'b0;
                  mem_write_en <= 1'b0;
                  resp_valid   <= 1'b1;
                  resp_rdata   <= write_q ? 32'h0000_0000 : {16'h0000, mem_rdata};
                  resp_err     <= err_q;
               end
            end
            S_BEAT1: begin
               state        <= S_RESP;
               mem_read_en  <= 1'b0;
               mem_write_en <= 1'b0;
               resp_valid   <= 1'b1;
               resp_rdata   <= write_q ? 32'h0000_0000 : {rdata_hi_q, mem_rdata};
               resp_err     <= err_q;
            end
            S_RESP: begin
               if (resp_ready) begin
                  state      <= S_IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: begin
               state        <= S_IDLE;
               mem_read_en  <= 1'b0;
               mem_write_en <= 1'b0;
               resp_valid   <= 1'b0;
               req_ready    <= 1'b0;
            end
         endcase
      end
   end

endmodule
